// File: rtl/text_pkg.sv
// Text renderer shared definitions: cell geometry, glyph codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package text_pkg;

  // Screen layout of the text buffer: 16 columns x 2 rows of 8x8 cells.
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 8;
  localparam int COLS      = 16;
  localparam int ROWS      = 2;
  localparam int NUM_CELLS = COLS * ROWS;

  // Glyph codes stored in the text RAM. Code 0 is blank.
  localparam logic [3:0] GLYPH_SPACE = 4'd0;
  localparam logic [3:0] GLYPH_0     = 4'd1;
  localparam logic [3:0] GLYPH_1     = 4'd2;
  localparam logic [3:0] GLYPH_2     = 4'd3;
  localparam logic [3:0] GLYPH_3     = 4'd4;
  localparam logic [3:0] GLYPH_4     = 4'd5;
  localparam logic [3:0] GLYPH_5     = 4'd6;
  localparam logic [3:0] GLYPH_6     = 4'd7;
  localparam logic [3:0] GLYPH_7     = 4'd8;
  localparam logic [3:0] GLYPH_8     = 4'd9;
  localparam logic [3:0] GLYPH_9     = 4'd10;
  localparam logic [3:0] GLYPH_A     = 4'd11;
  localparam logic [3:0] GLYPH_B     = 4'd12;
  localparam logic [3:0] GLYPH_C     = 4'd13;
  localparam logic [3:0] GLYPH_D     = 4'd14;
  localparam logic [3:0] GLYPH_E     = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/font_rom.sv
// 16-glyph 8x8 font lookup; row 0 is the top row, bit 7 the leftmost pixel.
// Latency: combinational.
// Backpressure: none.
// Ports: code = glyph code, row = glyph row 0..7, bits = pixel row (MSB = left).
module font_rom
  import text_pkg::*;
(
  input  logic [3:0] code,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  // Each glyph is packed as eight row bytes, top row in the most significant byte.
  logic [63:0] glyph;

  always_comb begin
    glyph = 64'h0;
    case (code)
      GLYPH_0: glyph = 64'h3C666E7666663C00;
      GLYPH_1: glyph = 64'h1838181818187E00;
      GLYPH_2: glyph = 64'h3C66060C30607E00;
      GLYPH_3: glyph = 64'h3C66061C06663C00;
      GLYPH_4: glyph = 64'h0C1C3C6C7E0C0C00;
      GLYPH_5: glyph = 64'h7E607C0606663C00;
      GLYPH_6: glyph = 64'h3C607C6666663C00;
      GLYPH_7: glyph = 64'h7E060C1830303000;
      GLYPH_8: glyph = 64'h3C66663C66663C00;
      GLYPH_9: glyph = 64'h3C66663E060C3800;
      GLYPH_A: glyph = 64'h183C66667E666600;
      GLYPH_B: glyph = 64'h7C66667C66667C00;
      GLYPH_C: glyph = 64'h3C66606060663C00;
      GLYPH_D: glyph = 64'h786C6666666C7800;
      GLYPH_E: glyph = 64'h7E60607860607E00;
      default: glyph = 64'h0;
    endcase
    // Row r lives at bits [8*(7-r) +: 8]; ~row gives 7-r for a 3-bit row.
    bits = glyph[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/text_renderer.sv
// Redraws the 32-cell text buffer as 8x8 glyphs into the frame buffer, one pixel write per cycle.
// Latency: 67 cycles per cell; done pulses 2144 cycles after start is accepted.
// Backpressure: none; the VGA adapter must accept a pixel every cycle plot is high.
// Ports: clock/resetn; start, cursor_en, cursor_addr (sampled in IDLE); ram_address/ram_q
// (text RAM, 1-cycle read latency); busy, done; x, y, colour, plot (to the VGA adapter).
module text_renderer
  import text_pkg::*;
#(
  parameter logic [7:0] X_ORIGIN  = 8'd16,
  parameter logic [6:0] Y_ORIGIN  = 7'd48,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       cursor_en,
  input  logic [4:0] cursor_addr,
  output logic [4:0] ram_address,
  input  logic [3:0] ram_q,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam logic [4:0] LAST_CELL = 5'(NUM_CELLS - 1);

  state_e     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic [5:0] pix_q, pix_d;
  logic [3:0] glyph_q, glyph_d;
  logic       inv_q, inv_d;
  logic       cur_en_q, cur_en_d;
  logic [4:0] cur_addr_q, cur_addr_d;
  logic [4:0] ram_address_q, ram_address_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] font_row;
  logic       font_bit;

  font_rom u_font_rom (
    .code (glyph_q),
    .row  (pix_q[5:3]),
    .bits (font_row)
  );

  // px = pix[2:0]; px 0 is the leftmost pixel, held in bit 7.
  assign font_bit = font_row[~pix_q[2:0]];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    pix_d         = pix_q;
    glyph_d       = glyph_q;
    inv_d         = inv_q;
    cur_en_d      = cur_en_q;
    cur_addr_d    = cur_addr_q;
    ram_address_d = ram_address_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    plot_d        = 1'b0;
    done_d        = 1'b0;

    // The RAM address is loaded on the edge entering FETCH so the RAM samples it
    // at the end of FETCH and ram_q is valid throughout WAIT.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_en_d      = cursor_en;
          cur_addr_d    = cursor_addr;
          addr_d        = 5'd0;
          ram_address_d = 5'd0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        glyph_d = ram_q;
        inv_d   = cur_en_q && (addr_q == cur_addr_q);
        pix_d   = 6'd0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        x_d      = X_ORIGIN + {1'b0, addr_q[3:0], 3'b000} + {5'b0, pix_q[2:0]};
        y_d      = Y_ORIGIN + {2'b0, addr_q[4], 3'b000} + {4'b0, pix_q[5:3]};
        colour_d = (font_bit ^ inv_q) ? FG_COLOUR : BG_COLOUR;
        plot_d   = 1'b1;
        pix_d    = pix_q + 6'd1;
        if (pix_q == 6'd63) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == LAST_CELL) begin
          done_d  = 1'b1;  // registered, so it is high during the DONE cycle
          state_d = S_DONE;
        end else begin
          addr_d        = addr_q + 5'd1;
          ram_address_d = addr_q + 5'd1;
          state_d       = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      addr_q        <= 5'd0;
      pix_q         <= 6'd0;
      glyph_q       <= 4'd0;
      inv_q         <= 1'b0;
      cur_en_q      <= 1'b0;
      cur_addr_q    <= 5'd0;
      ram_address_q <= 5'd0;
      x_q           <= 8'd0;
      y_q           <= 7'd0;
      colour_q      <= 3'd0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pix_q         <= pix_d;
      glyph_q       <= glyph_d;
      inv_q         <= inv_d;
      cur_en_q      <= cur_en_d;
      cur_addr_q    <= cur_addr_d;
      ram_address_q <= ram_address_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ram_address = ram_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;

endmodule

// File: tb/tb_text_renderer.sv
// Scoreboard bench for text_renderer: expected pixels are queued when start is driven
// and compared in order against every plotted pixel.
module tb_text_renderer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic       cursor_en;
  logic [4:0] cursor_addr;
  logic [4:0] ram_address;
  logic [3:0] ram_q;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  text_renderer dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .cursor_en   (cursor_en),
    .cursor_addr (cursor_addr),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .busy        (busy),
    .done        (done),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  always #5 clock = ~clock;

  // Text RAM model, one-cycle read latency.
  logic [3:0] ram [32];
  always @(posedge clock) ram_q <= ram[ram_address];

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] exp_q [$];
  logic [17:0] obs_q [$];
  int          addr_seq [$];
  int          extra_starts [$];
  int          mod_edge = -1;
  logic [3:0]  mod_val = 4'd0;
  int          t0, n_plot, n_done, done_edge, busy_fall;

  // Reference font: eight row bytes per glyph, top row first, MSB = leftmost pixel.
  function automatic logic [63:0] ref_font(input logic [3:0] g);
    case (g)
      4'd1:    return 64'h3C666E7666663C00;
      4'd2:    return 64'h1838181818187E00;
      4'd3:    return 64'h3C66060C30607E00;
      4'd4:    return 64'h3C66061C06663C00;
      4'd5:    return 64'h0C1C3C6C7E0C0C00;
      4'd6:    return 64'h7E607C0606663C00;
      4'd7:    return 64'h3C607C6666663C00;
      4'd8:    return 64'h7E060C1830303000;
      4'd9:    return 64'h3C66663C66663C00;
      4'd10:   return 64'h3C66663E060C3800;
      4'd11:   return 64'h183C66667E666600;
      4'd12:   return 64'h7C66667C66667C00;
      4'd13:   return 64'h3C66606060663C00;
      4'd14:   return 64'h786C6666666C7800;
      4'd15:   return 64'h7E60607860607E00;
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit is_extra(input int r);
    foreach (extra_starts[i]) if (extra_starts[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_expected(input logic ce, input logic [4:0] ca);
    logic [63:0] gl;
    logic        b;
    int          xx, yy;
    exp_q.delete();
    for (int a = 0; a < 32; a++) begin
      gl = ref_font(ram[a]);
      for (int py = 0; py < 8; py++) begin
        for (int px = 0; px < 8; px++) begin
          xx = 16 + 8 * (a % 16) + px;
          yy = 48 + 8 * (a / 16) + py;
          b  = gl[63 - 8 * py - px] ^ (ce && (a == int'(ca)));
          exp_q.push_back({8'(xx), 7'(yy), (b ? 3'b111 : 3'b000)});
        end
      end
    end
  endtask

  // Issues one start and records every output event for 2300 cycles.
  // rel = number of the last active edge, counting the start-sampling edge as 0.
  task automatic run_redraw(input logic ce, input logic [4:0] ca);
    int         rel;
    logic       busy_prev;
    logic [4:0] last_addr;
    obs_q.delete();
    addr_seq.delete();
    n_plot = 0; n_done = 0; done_edge = -1; busy_fall = -1;
    build_expected(ce, ca);
    @(negedge clock);
    start = 1'b1; cursor_en = ce; cursor_addr = ca;
    @(posedge clock);
    #1;
    t0 = cyc;
    start = 1'b0; cursor_en = 1'b0; cursor_addr = 5'd0;
    busy_prev = 1'b1;
    last_addr = 5'd0;
    for (int i = 0; i < 2300; i++) begin
      @(negedge clock);
      rel = cyc - t0;
      if (plot === 1'b1) begin
        obs_q.push_back({x, y, colour});
        n_plot++;
      end
      if (done === 1'b1) begin
        n_done++;
        done_edge = rel;
      end
      if (busy_prev && busy !== 1'b1 && busy_fall < 0) busy_fall = rel;
      busy_prev = (busy === 1'b1);
      if (rel == 0 || ram_address !== last_addr) addr_seq.push_back(int'(ram_address));
      last_addr = ram_address;
      if (rel == mod_edge) ram[3] = mod_val;
      start = is_extra(rel + 1);
    end
    start = 1'b0;
    extra_starts.delete();
    mod_edge = -1;
  endtask

  task automatic test_reset;
    resetn = 1'b1; start = 1'b0; cursor_en = 1'b0; cursor_addr = 5'd0;
    foreach (ram[i]) ram[i] = 4'd0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++; if (ram_address !== 5'd0) begin miscompares++; $display("FAIL reset_ram_address got %0d want 0", ram_address); end
    vectors++; if (x !== 8'd0)           begin miscompares++; $display("FAIL reset_x got %0d want 0", x); end
    vectors++; if (y !== 7'd0)           begin miscompares++; $display("FAIL reset_y got %0d want 0", y); end
    vectors++; if (colour !== 3'd0)      begin miscompares++; $display("FAIL reset_colour got %0d want 0", colour); end
    vectors++; if (plot !== 1'b0)        begin miscompares++; $display("FAIL reset_plot got %b want 0", plot); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_all_zero;
    logic [17:0] e, o;
    foreach (ram[i]) ram[i] = 4'd0;
    run_redraw(1'b0, 5'd0);
    vectors++; if (n_plot != 2048)     begin miscompares++; $display("FAIL zero_plot_count got %0d want 2048", n_plot); end
    vectors++; if (n_done != 1)        begin miscompares++; $display("FAIL zero_done_count got %0d want 1", n_done); end
    vectors++; if (done_edge != 2144)  begin miscompares++; $display("FAIL zero_done_edge got %0d want 2144", done_edge); end
    vectors++; if (busy_fall != 2145)  begin miscompares++; $display("FAIL zero_busy_fall got %0d want 2145", busy_fall); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL zero_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]); end
    end
  endtask

  task automatic test_first_glyph;
    logic [17:0] e, o;
    foreach (ram[i]) ram[i] = 4'd0;
    ram[0] = 4'd1;
    run_redraw(1'b0, 5'd0);
    vectors++; if (n_plot != 2048) begin miscompares++; $display("FAIL glyph1_plot_count got %0d want 2048", n_plot); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL glyph1_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]); end
    end
  endtask

  task automatic test_cursor;
    logic [17:0] e, o;
    foreach (ram[i]) ram[i] = 4'd0;
    ram[17] = 4'd5;
    run_redraw(1'b1, 5'd17);
    vectors++; if (n_plot != 2048) begin miscompares++; $display("FAIL cursor17_plot_count got %0d want 2048", n_plot); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL cursor17_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]); end
    end
    // A blank cell under the cursor becomes a solid foreground block.
    run_redraw(1'b1, 5'd4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL cursor_space_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] e, o;
    foreach (ram[i]) ram[i] = 4'($urandom_range(0, 15));
    extra_starts.push_back(100);
    extra_starts.push_back(2144);
    extra_starts.push_back(2145);
    run_redraw(1'b1, 5'($urandom_range(0, 31)));
    vectors++; if (n_done != 1)        begin miscompares++; $display("FAIL restart_done_count got %0d want 1", n_done); end
    vectors++; if (n_plot != 2048)     begin miscompares++; $display("FAIL restart_plot_count got %0d want 2048", n_plot); end
    vectors++; if (addr_seq.size() != 32) begin miscompares++; $display("FAIL restart_addr_len got %0d want 32", addr_seq.size()); end
    foreach (addr_seq[i]) begin
      vectors++;
      if (addr_seq[i] != i) begin miscompares++; $display("FAIL restart_addr_seq[%0d] got %0d want %0d", i, addr_seq[i], i); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL restart_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]); end
    end
  endtask

  // Cell 3 is fetched at edge 201 and read by the RAM at edge 202; the write at
  // rel 202 lands during WAIT, so ram_q still carries the old glyph.
  task automatic test_ram_change;
    logic [17:0] e, o;
    foreach (ram[i]) ram[i] = 4'($urandom_range(0, 15));
    ram[3]   = 4'd11;
    mod_val  = 4'd1;
    mod_edge = 202;
    run_redraw(1'b0, 5'd0);
    vectors++; if (ram[3] !== 4'd1) begin miscompares++; $display("FAIL ramchg_write got %0d want 1", ram[3]); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL ramchg_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]); end
    end
  endtask

  task automatic test_reset_mid_draw;
    int stray;
    foreach (ram[i]) ram[i] = 4'd11;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 30; i++) @(negedge clock);
    vectors++; if (plot !== 1'b1) begin miscompares++; $display("FAIL middraw_plot_before got %b want 1", plot); end
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    vectors++; if (plot !== 1'b0) begin miscompares++; $display("FAIL middraw_plot_async got %b want 0", plot); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL middraw_busy_async got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL middraw_done_async got %b want 0", done); end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (plot !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++; if (stray != 0) begin miscompares++; $display("FAIL middraw_stray_activity got %0d want 0", stray); end
    run_redraw(1'b0, 5'd0);
    vectors++; if (n_plot != 2048)    begin miscompares++; $display("FAIL middraw_redo_plots got %0d want 2048", n_plot); end
    vectors++; if (done_edge != 2144) begin miscompares++; $display("FAIL middraw_redo_done_edge got %0d want 2144", done_edge); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_first_glyph();
    test_cursor();
    test_back_to_back();
    test_ram_change();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Sits between the 32x4 text buffer RAM and the VGA adapter.
- On a start pulse it scans all 32 buffer entries. For each entry it reads the 4-bit glyph code and rasterises an 8x8 glyph from an internal font ROM, producing one (x, y, colour, plot) pixel write per cycle to the 160x120, 3-bit-colour frame buffer.
- The cursor cell is drawn with foreground and background colours swapped.
- Every glyph pixel is written, foreground or background, so a redraw also erases stale text.

Parameters:
- X_ORIGIN, 16, x pixel of the top-left corner of cell 0
- Y_ORIGIN, 48, y pixel of the top-left corner of cell 0
- FG_COLOUR, 3'b111, colour of glyph "on" pixels
- BG_COLOUR, 3'b000, colour of glyph "off" pixels

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to redraw the whole buffer; sampled only in IDLE
- cursor_en  in  1  enable cursor highlighting; sampled with start
- cursor_addr  in  5  buffer index of the cursor; sampled with start
- ram_address  out  5  read address to the text RAM
- ram_q  in  4  RAM read data, valid the cycle after the address is presented
- busy  out  1  high from start acceptance until return to IDLE; top level gives RAM address ownership to this block while high
- done  out  1  one-cycle pulse when the redraw completes
- x  out  8  pixel x to the VGA adapter
- y  out  7  pixel y to the VGA adapter
- colour  out  3  pixel colour to the VGA adapter
- plot  out  1  pixel write strobe to the VGA adapter

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - ram_address, x, y, colour, plot, busy and done go to 0.
  - Internal addr, pix and glyph registers clear.
  - Reset mid-redraw abandons the redraw immediately; no further plot pulses are issued.
- States: IDLE, FETCH, WAIT, DRAW, NEXT, DONE.
- IDLE: start=1 captures cursor_en/cursor_addr, sets addr=0, moves to FETCH. start in any other state is ignored.
- FETCH: ram_address=addr. Moves to WAIT.
- WAIT: latches glyph=ram_q. Sets inv = cursor_en_q && (addr==cursor_addr_q). Sets pix=0. Moves to DRAW.
- DRAW: 64 cycles, pix 0..63, with py=pix[5:3] and px=pix[2:0].
  - Each cycle registers x = X_ORIGIN + 8*addr[3:0] + px.
  - Each cycle registers y = Y_ORIGIN + 8*addr[4] + py.
  - Each cycle registers colour = (font_bit XOR inv) ? FG_COLOUR : BG_COLOUR, and plot=1.
  - font_bit is bit (7-px) of font row py for the latched glyph; the leftmost pixel is the MSB.
  - After pix==63, moves to NEXT.
- NEXT:
  - The final pixel's plot is still visible this cycle (registered output); plot is low in all other non-DRAW-following cycles.
  - If addr==31, moves to DONE. Otherwise addr+1 and moves to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing (edge 0 is the edge that samples start):
  - Char k enters FETCH at edge 67k.
  - Each char costs 67 cycles; plot is high exactly 64 cycles per char, 2048 in total.
  - DONE is entered at edge 2144. busy falls at edge 2145.
- Layout: 16 cells per row and 2 rows; address bit 4 selects the row.
  - Max x = 16+120+7 = 143 < 160. Max y = 48+8+7 = 63 < 120. No wrap or clipping is needed.
  - Arithmetic is done at 8/7-bit output widths. Parameter choices that overflow these widths are illegal.
- busy is high in every state except IDLE. ram_address holds its last value outside FETCH.
- Glyph code 0 is an all-off glyph (space). A space under the cursor renders as a solid FG block.

Decomposition:
- Package text_pkg holds:
  - CELL_W=8, CELL_H=8, COLS=16, ROWS=2, NUM_CELLS=32
  - glyph code constants (0=space, 1..15 per the font table)
  - the state enum
- Sub-module font_rom is purely combinational: in code[3:0], row[2:0]; out bits[7:0]. It holds the 16x8 font table.

Test Plan:
- Reset mid-DRAW: assert resetn=0 at edge 30 -> plot/busy/done go 0 asynchronously and no plot follows release; a new start then completes normally.
- All-zero RAM, start, cursor_en=0 -> exactly 2048 plot pulses, all colour=3'b000; done is a single pulse at edge 2144.
- RAM[0]=1, rest 0, cursor_en=0 -> the first 64 plots cover x 16..23, y 48..55 in raster order. Colours match font_rom(1) rows MSB-first.
- RAM[17]=5, cursor_en=1, cursor_addr=17 -> char 17 is plotted at x 24..31, y 56..63 with inverted colours. Char 16 (a space) is all 3'b000.
- Pulse start again at edge 100 and at edge 2144 -> both ignored: ram_address follows 0..31 exactly once and done pulses once.
- Model RAM with 1-cycle read latency and change RAM[3] during the redraw after its FETCH -> the glyph drawn for cell 3 is the value present at its WAIT cycle.
